uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among N_REQ byte-stream requesters.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and default byte width.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned BCNT_W         = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set req bit scanning ptr, ptr+1, ... with wrap.
// Ports:
//   req    - request vector
//   ptr    - index where the scan starts
//   onehot - winner as a one-hot vector (0 when no request)
//   index  - winner index (0 when no request)
//   found  - at least one request is set
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] index,
    output logic             found
);

    logic [PTR_W-1:0] cand;

    // Walk the requesters in rotated order; the first hit wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                index  = cand;
                onehot = N_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters with
// round-robin grants held for one packet or BURST_MAX bytes.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   req_valid  - requester i has a byte on req_data slice i
//   req_data   - packed bytes, slice i = [i*DATA_BITS +: DATA_BITS]
//   req_last   - byte on slice i ends its packet
//   req_ready  - one-hot accept strobe (registered)
//   grant      - one-hot transmitter owner, 0 when idle (registered)
//   tx_start   - one-cycle load pulse to the transmitter (registered)
//   tx_data    - byte for the transmitter, held until the next load (registered)
//   tx_busy    - transmitter frame in progress
//   active     - FSM is not idle (registered)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_BITS = UART_DATA_BITS,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           grant,
    output logic                       tx_start,
    output logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_busy,
    output logic                       active
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic                   last_q, last_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [N_REQ-1:0]       ready_q, ready_d;
    logic                   start_q, start_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   active_q, active_d;

    logic [N_REQ-1:0]       pick_oh;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [DATA_BITS-1:0]   data_arr [N_REQ];

    // Unpack the flat data bus so the owner's byte can be indexed directly.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .index  (pick_idx),
        .found  (pick_any)
    );

    // Next-state and registered-output logic; ready/start are pre-computed
    // one cycle ahead so they land in the LOAD/START cycles respectively.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        bcnt_d   = bcnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ready_d  = '0;
        start_d  = 1'b0;
        data_d   = data_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    bcnt_d  = '0;
                    ready_d = pick_oh;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = data_arr[gidx_q];
                last_d  = req_last[gidx_q];
                bcnt_d  = (bcnt_q == '1) ? bcnt_q : bcnt_q + BCNT_W'(1);
                start_d = 1'b1;
                state_d = START;
            end
            START: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (!last_q && (32'(bcnt_q) < BURST_MAX) && req_valid[gidx_q]) begin
                        ready_d = grant_q;
                        state_d = LOAD;
                    end else begin
                        grant_d = '0;
                        ptr_d   = (32'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + PTR_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            bcnt_q   <= '0;
            last_q   <= 1'b0;
            grant_q  <= '0;
            ready_q  <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            bcnt_q   <= bcnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            data_q   <= data_d;
            active_q <= active_d;
        end
    end

    assign req_ready = ready_q;
    assign grant     = grant_q;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign active    = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (BURST_MAX 16 and 2) share the
// requester inputs; bsel picks which one the requester model talks to.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    rdy_a, gnt_a, rdy_b, gnt_b;
    logic             st_a, st_b, act_a, act_b, busy_a, busy_b;
    logic [DW-1:0]    txd_a, txd_b;

    uart_tx_arbiter #(.N_REQ(NR), .DATA_BITS(DW), .BURST_MAX(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rdy_a), .grant(gnt_a), .tx_start(st_a),
        .tx_data(txd_a), .tx_busy(busy_a), .active(act_a));

    uart_tx_arbiter #(.N_REQ(NR), .DATA_BITS(DW), .BURST_MAX(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rdy_b), .grant(gnt_b), .tx_start(st_b),
        .tx_data(txd_b), .tx_busy(busy_b), .active(act_b));

    // Transmitter models: busy rises rise_dly cycles after the start pulse
    // and stays high for frame_len cycles.
    int rise_dly = 0, frame_len = 4;
    int tcnt_a = 0, tcnt_b = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             tcnt_a <= 0;
        else if (st_a)          tcnt_a <= rise_dly + frame_len;
        else if (tcnt_a > 0)    tcnt_a <= tcnt_a - 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             tcnt_b <= 0;
        else if (st_b)          tcnt_b <= rise_dly + frame_len;
        else if (tcnt_b > 0)    tcnt_b <= tcnt_b - 1;
    end
    assign busy_a = (tcnt_a != 0) && (tcnt_a <= frame_len);
    assign busy_b = (tcnt_b != 0) && (tcnt_b <= frame_len);

    bit            bsel = 1'b0;
    logic [NR-1:0] rdy_s, gnt_s;
    logic          st_s, act_s;
    logic [DW-1:0] txd_s;
    int            tcnt_s;
    assign rdy_s  = bsel ? rdy_b  : rdy_a;
    assign gnt_s  = bsel ? gnt_b  : gnt_a;
    assign st_s   = bsel ? st_b   : st_a;
    assign act_s  = bsel ? act_b  : act_a;
    assign txd_s  = bsel ? txd_b  : txd_a;
    assign tcnt_s = bsel ? tcnt_b : tcnt_a;

    // Requester byte queues: {last, data}.
    logic [8:0]  rq [NR][$];
    logic [8:0]  late_q [$];
    int          late_idx = -1;
    int          drop_idx = -1, drop_on = 0, drop_off = 0;
    logic [NR-1:0] drop_m = '0;
    logic [15:0] got_q [$];     // {src, data} per tx_start
    int          gcyc [$];
    logic [16:0] exp_q [$];     // {first_of_grant, src, data}
    int          cyc = 0;
    int          total = 0, bad = 0;

    typedef struct {
        bit              bsel;
        int              rise;
        int              frame;
        logic [0:3][7:0] base;
        logic [0:3][7:0] cnt;
        logic [3:0]      lastend;
        int              late;
        int              n;
        logic [0:7][15:0] exp;
    } row_t;
    row_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] oh2idx(input logic [NR-1:0] oh);
        oh2idx = 8'hFF;
        for (int i = 0; i < NR; i++) if (oh[i]) oh2idx = 8'(i);
    endfunction

    task automatic drive();
        logic [8:0] w;
        for (int i = 0; i < NR; i++) begin
            w = (rq[i].size() != 0) ? rq[i][0] : 9'h0;
            req_valid[i]        = (rq[i].size() != 0) && !drop_m[i];
            req_data[i*DW +: DW] = w[7:0];
            req_last[i]         = w[8];
        end
    endtask

    // One clock: retire accepted bytes, sample outputs, check invariants.
    task automatic step();
        logic [NR-1:0] acc;
        logic [8:0]    w;
        acc = rdy_s & req_valid;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) if (acc[i] && rq[i].size() != 0) w = rq[i].pop_front();
        check("ready_in_grant", 32'((rdy_s & ~gnt_s) == '0), 32'd1);
        check("grant_onehot0", 32'($onehot0(gnt_s)), 32'd1);
        if (st_s) begin
            check("no_start_in_frame", tcnt_s, 0);
            check("grant_at_start", 32'($onehot(gnt_s)), 32'd1);
            got_q.push_back({oh2idx(gnt_s), txd_s});
            gcyc.push_back(cyc);
            if (late_idx >= 0 && got_q.size() == 1)
                while (late_q.size() != 0) rq[late_idx].push_back(late_q.pop_front());
            if (drop_idx >= 0 && got_q.size() == drop_on)  drop_m[drop_idx] = 1'b1;
            if (drop_idx >= 0 && got_q.size() == drop_off) drop_m[drop_idx] = 1'b0;
        end
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) rq[i].delete();
        late_q.delete(); got_q.delete(); gcyc.delete(); exp_q.delete();
        late_idx = -1; drop_idx = -1; drop_m = '0;
        drive();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic load(input int i, input logic [7:0] base, input int cnt,
                        input bit lastend, input bit late);
        logic [8:0] w;
        for (int k = 0; k < cnt; k++) begin
            w = {lastend && (k == cnt - 1), base + 8'(k)};
            if (late) late_q.push_back(w);
            else      rq[i].push_back(w);
        end
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while ((got_q.size() < n || act_s) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) check("timeout", 32'(k), 32'(budget - 1));
        repeat (4) step();
        check("byte_count", 32'(got_q.size()), 32'(n));
    endtask

    function automatic logic [15:0] got_at(input int j);
        got_at = (j < got_q.size()) ? got_q[j] : 16'hDEAD;
    endfunction

    // Reference: grants follow from queue contents alone when all bytes are
    // queued up front (round robin, packet or burst boundary ends a grant).
    task automatic model(input int burst);
        logic [8:0] mq [NR][$];
        logic [8:0] w;
        int p = 0, g, n, left;
        left = 0;
        for (int i = 0; i < NR; i++) begin
            foreach (rq[i][k]) mq[i].push_back(rq[i][k]);
            left += rq[i].size();
        end
        while (left > 0) begin
            g = -1;
            for (int k = 0; k < NR; k++)
                if (g < 0 && mq[(p + k) % NR].size() != 0) g = (p + k) % NR;
            n = 0;
            do begin
                w = mq[g].pop_front();
                left--;
                n++;
                exp_q.push_back({n == 1, 8'(g), w[7:0]});
            end while (!w[8] && n < burst && mq[g].size() != 0);
            p = (g + 1) % NR;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        clear_all();

        tbl[0] = '{bsel: 0, rise: 0, frame: 10, base: {8'h00, 8'h41, 8'h00, 8'h00},
                   cnt: {8'd0, 8'd2, 8'd0, 8'd0}, lastend: 4'b0010, late: -1, n: 2,
                   exp: {16'h0141, 16'h0142, {6{16'h0}}}};
        tbl[1] = '{bsel: 0, rise: 0, frame: 4, base: {8'h10, 8'h00, 8'h20, 8'h00},
                   cnt: {8'd3, 8'd0, 8'd3, 8'd0}, lastend: 4'b0101, late: -1, n: 6,
                   exp: {16'h0010, 16'h0011, 16'h0012, 16'h0220, 16'h0221, 16'h0222, {2{16'h0}}}};
        tbl[2] = '{bsel: 1, rise: 0, frame: 3, base: {8'h50, 8'h00, 8'h00, 8'h30},
                   cnt: {8'd2, 8'd0, 8'd0, 8'd5}, lastend: 4'b0001, late: 0, n: 7,
                   exp: {16'h0330, 16'h0331, 16'h0050, 16'h0051, 16'h0332, 16'h0333, 16'h0334, 16'h0}};
        tbl[3] = '{bsel: 0, rise: 4, frame: 6, base: {8'h00, 8'h00, 8'h90, 8'h00},
                   cnt: {8'd0, 8'd0, 8'd3, 8'd0}, lastend: 4'b0100, late: -1, n: 3,
                   exp: {16'h0290, 16'h0291, 16'h0292, {5{16'h0}}}};

        // Reset values on both instances.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  32'(rdy_a | rdy_b), 0);
        check("rst_grant",  32'(gnt_a | gnt_b), 0);
        check("rst_start",  32'(st_a | st_b), 0);
        check("rst_data",   32'(txd_a | txd_b), 0);
        check("rst_active", 32'(act_a | act_b), 0);
        rst_n = 1'b1;
        step();
        check("idle_active", 32'(act_s), 0);

        // Table-driven scenarios.
        for (int r = 0; r < 4; r++) begin
            bsel = tbl[r].bsel;
            rise_dly = tbl[r].rise;
            frame_len = tbl[r].frame;
            reset_dut();
            late_idx = tbl[r].late;
            for (int i = 0; i < NR; i++)
                load(i, tbl[r].base[i], int'(tbl[r].cnt[i]), tbl[r].lastend[i], i == tbl[r].late);
            drive();
            run_until(tbl[r].n, 3000);
            for (int j = 0; j < tbl[r].n; j++) check($sformatf("row%0d_byte%0d", r, j), 32'(got_at(j)), 32'(tbl[r].exp[j]));
            for (int j = 1; j < gcyc.size(); j++)
                check($sformatf("row%0d_gap%0d", r, j), 32'(gcyc[j] - gcyc[j-1] >= rise_dly + frame_len + 3), 1);
        end

        // Latency from idle, then pointer after serving requester 1.
        bsel = 1'b0; rise_dly = 0; frame_len = 5;
        reset_dut();
        rq[1].push_back({1'b1, 8'hA5});
        drive();
        step();
        check("lat_ready",  32'(rdy_s), 32'h2);
        check("lat_grant",  32'(gnt_s), 32'h2);
        check("lat_active", 32'(act_s), 1);
        check("lat_nostart", 32'(st_s), 0);
        step();
        check("lat_start", 32'(st_s), 1);
        check("lat_data",  32'(txd_s), 32'hA5);
        check("lat_ready_drop", 32'(rdy_s), 0);
        run_until(1, 200);
        got_q.delete(); gcyc.delete();
        load(0, 8'hB0, 1, 1'b1, 1'b0);
        load(2, 8'hB2, 1, 1'b1, 1'b0);
        drive();
        run_until(2, 500);
        check("ptr_first",  32'(got_at(0)), 32'h02B2);
        check("ptr_second", 32'(got_at(1)), 32'h00B0);

        // Reset asserted while waiting for the frame to finish.
        frame_len = 10;
        reset_dut();
        load(1, 8'hD0, 2, 1'b1, 1'b0);
        drive();
        for (int k = 0; k < 100 && got_q.size() == 0; k++) step();
        check("mid_started", 32'(got_q.size()), 1);
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_grant",  32'(gnt_s), 0);
        check("arst_ready",  32'(rdy_s), 0);
        check("arst_start",  32'(st_s), 0);
        check("arst_data",   32'(txd_s), 0);
        check("arst_active", 32'(act_s), 0);
        clear_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load(1, 8'hE1, 1, 1'b1, 1'b0);
        load(3, 8'hE3, 1, 1'b1, 1'b0);
        drive();
        step();
        check("fresh_grant", 32'(gnt_s), 32'h2);
        run_until(2, 500);
        check("fresh_first",  32'(got_at(0)), 32'h01E1);
        check("fresh_second", 32'(got_at(1)), 32'h03E3);

        // Requester 2 withdraws after its first byte; requester 3 goes next.
        frame_len = 4;
        reset_dut();
        load(2, 8'h60, 4, 1'b1, 1'b0);
        load(3, 8'h70, 2, 1'b1, 1'b0);
        drop_idx = 2; drop_on = 1; drop_off = 3;
        drive();
        run_until(6, 1000);
        check("drop_b0", 32'(got_at(0)), 32'h0260);
        check("drop_b1", 32'(got_at(1)), 32'h0370);
        check("drop_b2", 32'(got_at(2)), 32'h0371);
        check("drop_b3", 32'(got_at(3)), 32'h0261);
        check("drop_b5", 32'(got_at(5)), 32'h0263);

        // Randomized traffic against the reference model.
        for (int rnd = 0; rnd < 8; rnd++) begin
            bsel = 1'($urandom_range(0, 1));
            rise_dly = $urandom_range(0, 3);
            frame_len = $urandom_range(1, 8);
            reset_dut();
            for (int i = 0; i < NR; i++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1) && ($urandom_range(0, 3) != 0), 8'($urandom)});
                end
            end
            if (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() == 0)
                rq[$urandom_range(0, 3)].push_back({1'b1, 8'($urandom)});
            model(bsel ? 2 : 16);
            drive();
            run_until(exp_q.size(), 5000);
            for (int j = 0; j < exp_q.size(); j++) begin
                check($sformatf("rnd%0d_byte%0d", rnd, j), 32'(got_at(j)), 32'(exp_q[j][15:0]));
                if (j > 0 && j < gcyc.size())
                    check($sformatf("rnd%0d_gap%0d", rnd, j), 32'(gcyc[j] - gcyc[j-1]),
                          32'(rise_dly + frame_len + 3 + (exp_q[j][16] ? 1 : 0)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
